// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped write-through L1 cache controller:
// default geometry, the controller state encoding and address-split helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_LINES  = 16;

   // Widest address the helper functions accept; callers cast down.
   localparam int unsigned MAX_ADDR_W = 64;

   typedef logic [MAX_ADDR_W-1:0] addr_max_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      WDONE
   } cache_state_t;

   // Line index: word address modulo the number of lines.
   function automatic addr_max_t addr_index(input addr_max_t addr, input int unsigned idx_w);
      addr_max_t mask;
      mask = (addr_max_t'(1) << idx_w) - addr_max_t'(1);
      return (addr >> 2) & mask;
   endfunction

   // Tag: everything above the byte offset and index fields.
   function automatic addr_max_t addr_tag(input addr_max_t addr, input int unsigned idx_w);
      return addr >> (2 + idx_w);
   endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_cpu_if / cache_mem_if
// Bus bundles around the cache controller.
//   cache_cpu_if : pipeline side. master = memory stage, slave = cache.
//      req, we, addr, wdata -> cache ; rdata, cache_ready -> pipeline
//   cache_mem_if : main-memory side. master = cache, slave = memory.
//      mem_req, mem_we, mem_addr, mem_wdata -> memory ; mem_rdata, mem_ack -> cache
// -----------------------------------------------------------------------------
interface cache_cpu_if
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              cache_ready;

   modport master (output req, we, addr, wdata, input  rdata, cache_ready);
   modport slave  (input  req, we, addr, wdata, output rdata, cache_ready);
endinterface

interface cache_mem_if
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cache_array.sv
// -----------------------------------------------------------------------------
// cache_array
// Valid/tag/data storage for a direct-mapped cache with one-word lines.
// Combinational read and synchronous write on a single shared index; only
// the valid bits are reset.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   idx_i                : line index for both read and write
//   rd_valid_o/tag_o/data_o : contents of line idx_i
//   we_i, tag_i, data_i  : write line idx_i (also marks it valid)
// -----------------------------------------------------------------------------
module cache_array
   import cache_pkg::*;
#(
   parameter int unsigned LINES  = DEF_LINES,
   parameter int unsigned TAG_W  = DEF_ADDR_W - 2 - $clog2(DEF_LINES),
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned IDX_W  = $clog2(LINES)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [IDX_W-1:0]  idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              we_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [DATA_W-1:0] data_i
);

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[idx_i]  <= tag_i;
         data_q[idx_i] <= data_i;
      end
   end

   assign rd_valid_o = valid_q[idx_i];
   assign rd_tag_o   = tag_q[idx_i];
   assign rd_data_o  = data_q[idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Blocking, direct-mapped, write-through, no-write-allocate L1 cache
// controller. Read hits complete in the request cycle; read misses and all
// writes stall the pipeline (cache_ready=0) until the memory handshake ends.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   cpu  : cache_cpu_if.slave  (req, we, addr, wdata / rdata, cache_ready)
//   mem  : cache_mem_if.master (mem_req, mem_we, mem_addr, mem_wdata /
//                               mem_rdata, mem_ack)
// -----------------------------------------------------------------------------
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned LINES  = DEF_LINES
) (
   input  logic        clk,
   input  logic        rst,
   cache_cpu_if.slave  cpu,
   cache_mem_if.master mem
);

   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

   cache_state_t state_q, state_d;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              line_valid;
   logic [TAG_W-1:0]  line_tag;
   logic [DATA_W-1:0] line_data;
   logic              hit;

   logic              arr_we;
   logic [DATA_W-1:0] arr_wdata;
   logic              ready;
   logic              mem_req;
   logic              mem_we;

   assign idx = IDX_W'(addr_index(addr_max_t'(cpu.addr), IDX_W));
   assign tag = TAG_W'(addr_tag(addr_max_t'(cpu.addr), IDX_W));
   assign hit = line_valid && (line_tag == tag);

   cache_array #(
      .LINES (LINES),
      .TAG_W (TAG_W),
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
   ) u_array (
      .clk_i     (clk),
      .rst_ni    (rst),
      .idx_i     (idx),
      .rd_valid_o(line_valid),
      .rd_tag_o  (line_tag),
      .rd_data_o (line_data),
      .we_i      (arr_we),
      .tag_i     (tag),
      .data_i    (arr_wdata)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cpu.req) begin
               if (cpu.we) begin
                  state_d = WRITE;
               end else if (!hit) begin
                  state_d = FILL;
               end
            end
         end
         FILL:    if (mem.mem_ack) state_d = IDLE;
         WRITE:   if (mem.mem_ack) state_d = WDONE;
         WDONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic. Memory strobes decode only state_q, so reset drops them
   // immediately and req never reaches mem_req combinationally.
   always_comb begin
      ready     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      arr_we    = 1'b0;
      arr_wdata = cpu.wdata;
      unique case (state_q)
         IDLE: begin
            ready  = !(cpu.req && (cpu.we || !hit));
            // Write hit updates the line now; tag/valid are rewritten unchanged.
            arr_we = cpu.req && cpu.we && hit;
         end
         FILL: begin
            mem_req   = 1'b1;
            arr_we    = mem.mem_ack;
            arr_wdata = mem.mem_rdata;
         end
         WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         WDONE:   ready = 1'b1;
         default: ;
      endcase
   end

   assign cpu.cache_ready = ready;
   assign cpu.rdata       = line_data;
   assign mem.mem_req     = mem_req;
   assign mem.mem_we      = mem_we;
   assign mem.mem_addr    = {cpu.addr[ADDR_W-1:2], 2'b00};
   assign mem.mem_wdata   = cpu.wdata;

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Blocking, direct-mapped, write-through L1 cache controller between the pipeline memory stage and main memory. It produces `cache_ready`, which feeds the hazard unit's global stall: `cache_ready` low freezes the pipeline. Read hits complete in the request cycle. Read misses, and all writes, hold `cache_ready` low until the memory handshake finishes.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width; lines are one word
- `LINES`, 16, number of lines; power of two, ≥2; `IDX_W = log2(LINES)`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  1  pipeline access request
- `we`  in  1  1 = write, 0 = read
- `addr`  in  ADDR_W  byte address; bits [1:0] ignored
- `wdata`  in  DATA_W  write data
- `rdata`  out  DATA_W  read data, valid when `req && !we && cache_ready`
- `cache_ready`  out  1  0 = stall the pipeline
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  memory write
- `mem_addr`  out  ADDR_W  word-aligned memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion pulse

## Operation
- Address split: index = `addr[2 +: IDX_W]`; tag = `addr[ADDR_W-1 : 2+IDX_W]`. Hit = valid[index] && tag match.
- Storage: valid bits, tag array, data array. Tag and data are read combinationally and written on the clock edge.
- FSM states:
  - IDLE:
    - No `req`: stay in IDLE.
    - Read hit: `rdata` = line data, `cache_ready`=1, stay in IDLE.
    - Read miss: go to FILL.
    - Write: if hit, update the data word at the edge. Go to WRITE in both cases (no-write-allocate on miss).
  - FILL: `mem_req`=1, `mem_we`=0, `mem_addr` = `{addr[ADDR_W-1:2],2'b00}`. On `mem_ack`, write the line (valid=1, tag, `mem_rdata`) and go to IDLE. The held read then hits.
  - WRITE: `mem_req`=1, `mem_we`=1, `mem_wdata`=`wdata`. On `mem_ack`, go to WDONE.
  - WDONE: `cache_ready`=1 for exactly one cycle, so the pipeline retires the write. No array or memory action. Go to IDLE.
- `cache_ready` (combinational) is 1 in WDONE, and 1 in IDLE unless (`req` && (`we` || miss)). It is 0 in FILL and WRITE.
- A FILL to an occupied index overwrites the old line; no writeback is needed (write-through).
- Requester contract: `req`, `we`, `addr` and `wdata` stay stable while `cache_ready`=0.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, all valid bits=0, `mem_req`=0, `mem_we`=0. Tag and data arrays are not reset.
- Outputs while `rst`=0: `mem_addr`, `mem_wdata` and `rdata` = 0 or don't-care; `cache_ready`=1 when `req`=0.
- Reset asserted mid-FILL or mid-WRITE: `mem_req` drops in the same cycle. The transaction is abandoned and a later `mem_ack` is ignored.
- Read hit: 0 extra cycles.
- Read miss: `cache_ready` is 0 from the request cycle through the `mem_ack` cycle, then 1 on the next cycle (the hit). Stall = 1 + memory latency cycles.
- Write: `cache_ready` is 0 from the request cycle through the `mem_ack` cycle, then 1 in WDONE.
- `mem_ack` is legal in the first cycle of `mem_req`. `mem_ack` seen in IDLE or WDONE is ignored.
- `mem_req` and `mem_we` are registered from state; no combinational path from `req` to `mem_req`.

## Structure
- Package `cache_pkg`:
  - State enum `cache_state_t` {IDLE, FILL, WRITE, WDONE}
  - Default parameter constants
  - Helper functions for index and tag extraction
- Sub-module `cache_array`: valid, tag and data storage, with combinational read, synchronous write, and valid clear on reset. The top level holds the FSM and hit logic.

## Test plan
- Reset, then read 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles: `cache_ready` low for 4 cycles with `mem_addr`=0x40; next cycle `rdata`=0xDEAD_BEEF with `cache_ready`=1; an immediate re-read hits with no stall.
- Conflict: read 0x40, then 0x440 (same index with `LINES`=16, different tag), then 0x40 again: three misses, each issuing `mem_req`.
- Write hit to 0x40 with 0x1234_5678 and `mem_ack` after 2 cycles: `mem_we`=1, `mem_wdata`=0x1234_5678, one WDONE cycle with `cache_ready`=1; a following read of 0x40 hits and returns 0x1234_5678.
- Write miss to 0x80: memory written; a following read of 0x80 misses (no allocate).
- `mem_ack` in the same cycle `mem_req` rises, on a read miss: fill completes, and `cache_ready` returns to 1 on the next cycle.
- Assert `rst` during FILL, with a stray `mem_ack` after release: `mem_req`=0 immediately; the stray ack is ignored; read 0x40 misses again.
